// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between two requesters:
//   port 0 : processor (normal priority winner)
//   port 1 : loader / debug (secondary, protected against starvation)
//
// Handshake: a requester raises pN_req with pN_we/pN_addr/pN_wdata and keeps
// them stable until it sees pN_gnt high in the same cycle; the transfer happens
// in that grant cycle. Nothing is queued inside the arbiter: an ungranted
// request exists only while req is held, so dropping req before gnt cancels it.
// A granted read returns pN_rvalid/pN_rdata exactly one cycle later.
//
// Ports
//   clock, reset              : single clock, synchronous active-high reset
//   pN_req/we/addr/wdata      : requester inputs (N = 0, 1)
//   pN_gnt                    : combinational grant
//   pN_rvalid/pN_rdata        : read return, rdata forced to 0 when not valid
//   address_dmem/data/wren    : shared dmem command (all 0 when idle)
//   q_dmem                    : dmem read data, valid the cycle after the read
//   conflict_count            : saturating count of cycles where both requested
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 12,
    parameter int DW           = 32
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic [AW-1:0] address_dmem,
    output logic [DW-1:0] data,
    output logic          wren,
    input  logic [DW-1:0] q_dmem,

    output logic [15:0]   conflict_count
);

    // Counter wide enough to hold STARVE_LIMIT itself (at least one bit).
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [15:0]   conflict_q,   conflict_d;
    logic          rvalid0_q,    rvalid0_d;
    logic          rvalid1_q,    rvalid1_d;

    logic          both_req;
    logic          p1_forced;
    logic          gnt0;
    logic          gnt1;

    // ------------------------------------------------------------------
    // Grant decision. Port 0 wins a conflict unless port 1 has already
    // been denied STARVE_LIMIT consecutive cycles. No grant while reset
    // is high so the memory sees no command during reset.
    // ------------------------------------------------------------------
    always_comb begin
        both_req  = p0_req & p1_req;
        p1_forced = (starve_cnt_q == STARVE_MAX);
        gnt0      = ~reset & p0_req & ~(p1_req & p1_forced);
        gnt1      = ~reset & p1_req & ~gnt0;
    end

    assign p0_gnt = gnt0;
    assign p1_gnt = gnt1;

    // ------------------------------------------------------------------
    // Memory command mux: grants are one-hot so a priority mux is exact.
    // ------------------------------------------------------------------
    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (gnt0) begin
            address_dmem = p0_addr;
            data         = p0_wdata;
            wren         = p0_we;
        end else if (gnt1) begin
            address_dmem = p1_addr;
            data         = p1_wdata;
            wren         = p1_we;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        // Starvation counter: counts consecutive denied cycles of port 1,
        // clears on grant or when port 1 withdraws, capped at the limit.
        starve_cnt_d = '0;
        if (p1_req && !gnt1) begin
            if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + SW'(1);
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end

        conflict_d = conflict_q;
        if (both_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end

        // Read return is tagged by port at grant time, so the following
        // cycle's grant winner cannot redirect the data.
        rvalid0_d = gnt0 & ~p0_we;
        rvalid1_d = gnt1 & ~p1_we;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            conflict_q   <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            conflict_q   <= conflict_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

    // ------------------------------------------------------------------
    // Read return. A read granted just before reset rises would have its
    // rvalid flop set during the first reset cycle; masking with reset
    // keeps that stale return from ever reaching the requester.
    // ------------------------------------------------------------------
    always_comb begin
        p0_rvalid = rvalid0_q & ~reset;
        p1_rvalid = rvalid1_q & ~reset;
        p0_rdata  = p0_rvalid ? q_dmem : '0;
        p1_rdata  = p1_rvalid ? q_dmem : '0;
    end

    assign conflict_count = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives both requesters, models the dmem as a synchronous single-port RAM,
// and compares every DUT output each cycle against a transaction-level
// reference: who should win (from the starvation rule), what the memory
// should hold (associative array), and which read return is due next
// (expected queue).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int AW           = 12;
  localparam int DW           = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] address_dmem;
  logic [DW-1:0] data;
  logic          wren;
  logic [DW-1:0] q_dmem;
  logic [15:0]   conflict_count;

  dmem_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .AW(AW),
    .DW(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .p0_req(p0_req),
    .p0_we(p0_we),
    .p0_addr(p0_addr),
    .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req),
    .p1_we(p1_we),
    .p1_addr(p1_addr),
    .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata),
    .address_dmem(address_dmem),
    .data(data),
    .wren(wren),
    .q_dmem(q_dmem),
    .conflict_count(conflict_count)
  );

  // ---------------- memory contents before any write ----------------
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 32'h010) return 32'hDEADBEEF;
    return {20'hA5C00, a[11:0]};
  endfunction

  // ---------------- dmem model (synchronous, read-first) ----------------
  logic [DW-1:0] dmem    [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];

  always @(posedge clock) begin
    q_dmem <= written[address_dmem] ? dmem[address_dmem] : init_val(int'(address_dmem));
    if (wren) begin
      dmem[address_dmem]    <= data;
      written[address_dmem] <= 1'b1;
    end
  end

  // ---------------- scoreboard / reference state ----------------
  logic [DW:0]   exp_q[$];      // {port, read data} of reads awaiting return
  logic [DW-1:0] ref_mem[int];  // only addresses written by the bench's traffic
  int            waited;        // consecutive cycles port 1 has been refused
  int            conflicts;
  int            last_win;      // -1 none, 0 or 1
  logic          obs_g1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // One cycle: called just after the negedge with inputs already applied.
  // Checks every output, then advances the reference at the posedge.
  task automatic step();
    int            win;
    logic [DW:0]   ent;
    logic          erv0, erv1;
    logic [DW-1:0] erd0, erd1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;

    #1;
    // who should own the memory this cycle
    win = -1;
    if (!reset) begin
      if (p0_req && p1_req) win = (waited >= STARVE_LIMIT) ? 1 : 0;
      else if (p0_req)      win = 0;
      else if (p1_req)      win = 1;
    end
    ea = '0; ed = '0; ew = 1'b0;
    if (win == 0) begin ea = p0_addr; ed = p0_wdata; ew = p0_we; end
    if (win == 1) begin ea = p1_addr; ed = p1_wdata; ew = p1_we; end

    // read return due this cycle
    erv0 = 1'b0; erv1 = 1'b0; erd0 = '0; erd1 = '0;
    if (exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      if (!reset) begin
        if (ent[DW]) begin erv1 = 1'b1; erd1 = ent[DW-1:0]; end
        else         begin erv0 = 1'b1; erd0 = ent[DW-1:0]; end
      end
    end

    check_eq("gnt0",     32'(p0_gnt),       32'(win == 0));
    check_eq("gnt1",     32'(p1_gnt),       32'(win == 1));
    check_eq("addr",     32'(address_dmem), 32'(ea));
    check_eq("wdata",    data,              ed);
    check_eq("wren",     32'(wren),         32'(ew));
    check_eq("rvalid0",  32'(p0_rvalid),    32'(erv0));
    check_eq("rdata0",   p0_rdata,          erd0);
    check_eq("rvalid1",  32'(p1_rvalid),    32'(erv1));
    check_eq("rdata1",   p1_rdata,          erd1);
    check_eq("conflict", 32'(conflict_count), 32'(conflicts));
    obs_g1   = p1_gnt;
    last_win = win;

    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      waited    = 0;
      conflicts = 0;
    end else begin
      if (p0_req && p1_req && conflicts < 16'hFFFF) conflicts++;
      if (p1_req && win != 1) waited = (waited < STARVE_LIMIT) ? waited + 1 : STARVE_LIMIT;
      else                    waited = 0;
      if (win == 0) begin
        if (p0_we) ref_mem[int'(p0_addr)] = p0_wdata;
        else       exp_q.push_back({1'b0, ref_read(int'(p0_addr))});
      end
      if (win == 1) begin
        if (p1_we) ref_mem[int'(p1_addr)] = p1_wdata;
        else       exp_q.push_back({1'b1, ref_read(int'(p1_addr))});
      end
    end
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_p0(input logic req, input logic we, input int addr, input logic [DW-1:0] wd);
    p0_req = req; p0_we = we; p0_addr = AW'(addr); p0_wdata = wd;
  endtask

  task automatic drive_p1(input logic req, input logic we, input int addr, input logic [DW-1:0] wd);
    p1_req = req; p1_we = we; p1_addr = AW'(addr); p1_wdata = wd;
  endtask

  task automatic idle();
    drive_p0(1'b0, 1'b0, 0, '0);
    drive_p1(1'b0, 1'b0, 0, '0);
  endtask

  // Random traffic; a pending (ungranted) request is usually held unchanged,
  // occasionally dropped/replaced, which the arbiter treats as a cancel.
  task automatic rand_drive();
    if (!(p0_req && last_win != 0 && $urandom_range(0, 9) != 0))
      drive_p0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom());
    if (!(p1_req && last_win != 1 && $urandom_range(0, 9) != 0))
      drive_p1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom());
    reset = ($urandom_range(0, 99) == 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    waited = 0; conflicts = 0; last_win = -1; obs_g1 = 1'b0;
    reset = 1'b1;
    // Requests present during reset must not be granted or counted.
    drive_p0(1'b1, 1'b1, 5, 32'h1111_1111);
    drive_p1(1'b1, 1'b1, 6, 32'h2222_2222);
    repeat (3) step();
    reset = 1'b0;

    // single read on port 0
    idle();
    drive_p0(1'b1, 1'b0, 32'h010, '0);
    step();
    idle();
    check_eq("rd_rvalid0", 32'(p0_rvalid), 32'd1);
    check_eq("rd_rdata0",  p0_rdata,       32'hDEADBEEF);
    check_eq("rd_rvalid1", 32'(p1_rvalid), 32'd0);
    step();

    // write then read on port 1
    drive_p1(1'b1, 1'b1, 32'h0FF, 32'h12345678);
    step();
    drive_p1(1'b1, 1'b0, 32'h0FF, '0);
    check_eq("wr_no_rvalid", 32'(p1_rvalid), 32'd0);
    step();
    idle();
    check_eq("wr_rd_data", p1_rdata, 32'h12345678);
    step();

    // starvation: both requesting continuously
    drive_p0(1'b1, 1'b0, 3, '0);
    drive_p1(1'b1, 1'b0, 4, '0);
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("starve_pat", 32'(obs_g1), 32'(i % 5 == 4));
      if (i == 9) check_eq("conflict10", 32'(conflict_count), 32'd10);
    end

    // reset while a port-0 read return is in flight
    step();  // p0 read granted here
    reset = 1'b1;
    #1;
    check_eq("rst_gnt0",   32'(p0_gnt),    32'd0);
    check_eq("rst_gnt1",   32'(p1_gnt),    32'd0);
    check_eq("rst_rvalid", 32'(p0_rvalid), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    check_eq("rst_conflict", 32'(conflict_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("post_rst_pat", 32'(obs_g1), 32'(i == 4));
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end
    reset = 1'b0;

    // saturation of conflict_count
    drive_p0(1'b1, 1'b0, 7, '0);
    drive_p1(1'b1, 1'b0, 8, '0);
    repeat (70000) step();
    check_eq("sat", 32'(conflict_count), 32'h0000FFFF);
    repeat (3) step();
    check_eq("sat_hold", 32'(conflict_count), 32'h0000FFFF);

    // idle bus
    idle();
    #1;
    check_eq("idle_wren", 32'(wren),         32'd0);
    check_eq("idle_addr", 32'(address_dmem), 32'd0);
    check_eq("idle_data", data,              32'd0);
    check_eq("idle_gnt",  32'({p0_gnt, p1_gnt}), 32'd0);
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive cycles port 1 may be denied before it is forced a grant.
REQ-002 The block SHALL have parameter AW, default 12, meaning the dmem word-address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-004 The block SHALL have port clock  in  1  single clock for all state; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset  in  1  reset; it SHALL be synchronous and active-high.
REQ-006 The block SHALL have ports p0_req in 1, p0_we in 1, p0_addr in AW, p0_wdata in DW: processor request, write enable, address and write data.
REQ-007 The block SHALL have ports p0_gnt out 1, p0_rvalid out 1, p0_rdata out DW: processor grant, read-data valid and read data.
REQ-008 The block SHALL have ports p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata with the same directions and widths as port 0, serving the secondary requester (loader/debug).
REQ-009 The block SHALL have ports address_dmem out AW, data out DW, wren out 1, q_dmem in DW: the shared single-port dmem interface.
REQ-010 The block SHALL have port conflict_count  out 16  saturating count of cycles in which both ports requested.

Function
REQ-011 Grants SHALL be combinational from the current req inputs and the registered starvation counter (starve_cnt), with at most one of p0_gnt/p1_gnt high.
REQ-012 If only one port requests, that port SHALL be granted in the same cycle.
REQ-013 If both ports request, port 0 SHALL be granted unless starve_cnt == STARVE_LIMIT, in which case port 1 SHALL be granted.
REQ-014 starve_cnt SHALL increment when p1_req && !p1_gnt, clear to 0 when p1_gnt or !p1_req, and never exceed STARVE_LIMIT.
REQ-015 The granted port's addr, wdata and we SHALL drive address_dmem, data and wren in the grant cycle; with no grant, address_dmem, data and wren SHALL be 0.
REQ-016 Requesters SHALL hold req/we/addr/wdata stable until gnt; the block SHALL NOT latch ungranted requests, and dropping req before gnt SHALL cancel the request.
REQ-017 A granted read (we=0) SHALL raise that port's rvalid for exactly the next cycle, with rdata = q_dmem during that cycle.
REQ-018 px_rdata SHALL be 0 whenever px_rvalid is 0; a granted write SHALL produce no rvalid.
REQ-019 Back-to-back grants SHALL be supported every cycle; the read latency SHALL be 1 cycle irrespective of which port is granted in the following cycle.
REQ-020 conflict_count SHALL increment in each cycle with p0_req && p1_req and saturate at 16'hFFFF.

Reset
REQ-021 While reset is high, p0_gnt, p1_gnt and wren SHALL be 0, and address_dmem and data SHALL be 0.
REQ-022 At the clock edge with reset high, starve_cnt, both rvalid registers and conflict_count SHALL clear to 0.
REQ-023 A read granted in the cycle before reset is asserted SHALL have its rvalid suppressed; no rvalid SHALL appear in the first cycle after reset deasserts.

Verification
REQ-024 Single read: p0 read at addr 0x010 holding 0xDEADBEEF -> p0_gnt high that cycle, address_dmem=0x010, wren=0; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p1_rvalid=0.
REQ-025 Write then read: p1 writes 0x12345678 to 0x0FF, then p1 reads 0x0FF -> wren=1 only in the write cycle, no rvalid after the write; p1_rdata=0x12345678 one cycle after the read grant.
REQ-026 Starvation: both ports request continuously with STARVE_LIMIT=4 -> p0 granted 4 cycles, then p1 for 1 cycle, repeating (pattern 0,0,0,0,1); conflict_count=10 after 10 cycles.
REQ-027 Reset mid-read: p0 read granted, then reset high next edge -> p0_rvalid stays 0, starve_cnt and conflict_count are 0, and no grant is issued while reset is high.
REQ-028 Saturation and idle: hold both req for 70000 cycles -> conflict_count=16'hFFFF and holds there; with no requests -> wren=0, address_dmem=0, data=0, both gnt=0.
